// File: rtl/program_counter_if.sv
// Control-unit / instruction-memory side of the program counter.
interface program_counter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             load;
  logic             inc;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;

  // Control unit drives load/inc/target, observes the address.
  modport master (output load, output inc, output in, input out);
  // Program counter consumes controls, drives the address.
  modport slave  (input load, input inc, input in, output out);
endinterface

// File: rtl/program_counter.sv
// Program counter: each rising edge loads a jump target, increments, or holds.
// The asynchronous active-high reset clears the address to 0.
module program_counter #(
  parameter int unsigned WIDTH = 16
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             reset,
  input  logic             clk
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Next address: load has priority over increment; the increment wraps modulo 2**WIDTH.
  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = in;
    end else if (inc) begin
      out_d = out_q + WIDTH'(1);
    end
  end

  // Address register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver pushes expected addresses,
// and monitors pop and compare them after each edge or immediate-reset event.
module tb_program_counter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned MODV  = 1 << WIDTH;

  typedef struct {
    logic [WIDTH-1:0] exp;
    string            name;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   model;
  exp_t sb_q[$];
  event imm_ev;

  program_counter_if #(.WIDTH(WIDTH)) pc_bus ();

  program_counter #(.WIDTH(WIDTH)) dut (
    .out   (pc_bus.out),
    .in    (pc_bus.in),
    .load  (pc_bus.load),
    .inc   (pc_bus.inc),
    .reset (reset),
    .clk   (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, queued=%0d", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic compare_one(input string when_s);
    exp_t e;
    e = sb_q.pop_front();
    total++;
    if (pc_bus.out !== e.exp) begin
      bad++;
      $display("FAIL %s (%s) t=%0t: got 0x%04h, want 0x%04h", e.name, when_s, $time, pc_bus.out, e.exp);
    end
  endtask

  // Edge monitor: one expectation per rising edge that the driver prepared.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) compare_one("edge");
    end
  end

  // Immediate monitor: checks that reset acts without waiting for an edge.
  initial begin
    forever begin
      @(imm_ev);
      #1;
      if (sb_q.size() != 0) compare_one("async");
    end
  end

  function automatic int ref_next(input logic r, input logic ld, input logic ic, input int din, input int cur);
    if (r)  return 0;
    if (ld) return din % MODV;
    if (ic) return (cur + 1) % MODV;
    return cur;
  endfunction

  task automatic push_exp(input int v, input string nm);
    exp_t e;
    e.exp  = WIDTH'(v);
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // One clocked transaction: drive at the falling edge, expect after the next rising edge.
  task automatic step(input logic r, input logic ld, input logic ic, input int din, input string nm);
    @(negedge clk);
    reset       = r;
    pc_bus.load = ld;
    pc_bus.inc  = ic;
    pc_bus.in   = WIDTH'(din);
    model = ref_next(r, ld, ic, din, model);
    push_exp(model, nm);
  endtask

  // Raise reset mid-cycle and expect an immediate clear.
  task automatic assert_reset(input logic ld, input logic ic, input string nm);
    @(negedge clk);
    pc_bus.load = ld;
    pc_bus.inc  = ic;
    #2;
    reset = 1'b1;
    model = 0;
    push_exp(0, nm);
    -> imm_ev;
  endtask

  // Short reset pulse between edges, then normal operation on the next edge.
  task automatic pulse_reset(input logic ld, input logic ic, input int din, input string nm);
    assert_reset(ld, ic, {nm, "_clear"});
    pc_bus.in = WIDTH'(din);
    #2;
    reset = 1'b0;
    model = ref_next(1'b0, ld, ic, din, 0);
    push_exp(model, {nm, "_after"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model = 0;
    reset       = 1'b0;
    pc_bus.load = 1'b0;
    pc_bus.inc  = 1'b0;
    pc_bus.in   = '0;

    // Reset asserted mid-cycle, then held across edges.
    assert_reset(1'b0, 1'b0, "reset_immediate");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, "reset_hold");
    step(1'b1, 1'b1, 1'b1, 16'h5555, "reset_beats_load_inc");

    // Increment / hold alternation, then two consecutive increments.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 65535)), "inc_step");
      step(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 65535)), "hold_step");
    end
    step(1'b0, 1'b0, 1'b1, 0, "inc_to_6");
    step(1'b0, 1'b0, 1'b1, 0, "inc_to_7");

    // Load, and load priority over increment.
    step(1'b0, 1'b1, 1'b0, 16'h1234, "load_1234");
    step(1'b0, 1'b1, 1'b1, 16'h00ff, "load_beats_inc");

    // Wrap-around.
    step(1'b0, 1'b1, 1'b0, 16'hffff, "load_ffff");
    step(1'b0, 1'b0, 1'b1, 0, "wrap_to_0");
    step(1'b0, 1'b0, 1'b1, 0, "inc_after_wrap");

    // Reset pulse between edges while incrementing from 7.
    step(1'b0, 1'b1, 1'b0, 16'h0007, "load_7");
    pulse_reset(1'b0, 1'b1, 0, "midop_reset");

    // Idle with a wandering jump target must hold.
    step(1'b0, 1'b1, 1'b0, 16'hbeef, "load_beef");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 65535)), "idle_in_toggle");

    // Randomised traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        pulse_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), "rand_reset");
      end else if (sel == 1) begin
        step(1'b0, 1'b1, 1'b0, 16'hffff, "rand_load_max");
      end else begin
        step(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 65535)), "rand_op");
      end
    end

    @(negedge clk);
    pc_bus.load = 1'b0;
    pc_bus.inc  = 1'b0;
    repeat (3) @(negedge clk);

    // Every prepared expectation must have been consumed by a monitor.
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
